// File: rtl/vred_seq_pkg.sv
// Shared encodings for the sequential vector reduction unit: FSM states,
// element-width codes and operation-select codes.
package vred_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ACCUM  = 3'd1,
        ST_FOLD   = 3'd2,
        ST_SCALAR = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    localparam logic [1:0] SEW_8    = 2'd0;
    localparam logic [1:0] SEW_16   = 2'd1;
    localparam logic [1:0] SEW_32   = 2'd2;
    localparam logic [1:0] SEW_RSVD = 2'd3;

    localparam logic [1:0] OP_SUM0 = 2'b00;
    localparam logic [1:0] OP_SUM1 = 2'b01;
    localparam logic [1:0] OP_MIN  = 2'b10;
    localparam logic [1:0] OP_MAX  = 2'b11;

endpackage

// File: rtl/vred_lane_op.sv
// Combinational per-lane reduction step: wrap-around sum or signed min/max,
// evaluated for every element width and selected by sew.
module vred_lane_op
    import vred_seq_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic [1:0]            sew,
    input  logic [1:0]            opSel,
    output logic [DATA_WIDTH-1:0] y
);

    logic [DATA_WIDTH-1:0] w_res [3];

    // gw selects lane width 8/16/32; lanes never exchange carries.
    genvar gw, gi;
    generate
        for (gw = 0; gw < 3; gw++) begin : g_width
            localparam int LW = 8 << gw;
            for (gi = 0; gi < DATA_WIDTH / LW; gi++) begin : g_lane
                logic [LW-1:0] w_a;
                logic [LW-1:0] w_b;
                logic          w_lt;
                assign w_a  = a[gi*LW +: LW];
                assign w_b  = b[gi*LW +: LW];
                assign w_lt = $signed(w_a) < $signed(w_b);
                assign w_res[gw][gi*LW +: LW] =
                    (opSel == OP_MIN) ? (w_lt ? w_a : w_b) :
                    (opSel == OP_MAX) ? (w_lt ? w_b : w_a) :
                                        w_a + w_b;
            end
        end
    endgenerate

    always_comb begin
        y = w_res[2];
        case (sew)
            SEW_8:   y = w_res[0];
            SEW_16:  y = w_res[1];
            default: y = w_res[2];
        endcase
    end

endmodule

// File: rtl/vred_seq.sv
// Sequential vector reduction: accumulates packed source words lane-wise,
// folds the lanes down to one element, then combines with the scalar operand.
module vred_seq
    import vred_seq_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int OPSEL_WIDTH = 2,
    parameter int SEW_WIDTH   = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [SEW_WIDTH-1:0]   sew,
    input  logic [OPSEL_WIDTH-1:0] opSel,
    input  logic [DATA_WIDTH-1:0]  scalar_in,
    input  logic                   in_valid,
    input  logic [DATA_WIDTH-1:0]  in_data,
    input  logic                   in_last,
    output logic                   in_ready,
    output logic                   out_valid,
    output logic [DATA_WIDTH-1:0]  out_data,
    input  logic                   out_ready,
    output logic                   busy
);

    localparam int F8  = $clog2(DATA_WIDTH / 8);
    localparam int F16 = $clog2(DATA_WIDTH / 16);
    localparam int F32 = $clog2(DATA_WIDTH / 32);

    state_t                  r_state, w_state_next;
    logic [DATA_WIDTH-1:0]   r_acc;
    logic                    r_first;
    logic [3:0]              r_fold;
    logic [SEW_WIDTH-1:0]    r_sew;
    logic [OPSEL_WIDTH-1:0]  r_opsel;
    logic [DATA_WIDTH-1:0]   r_scalar;

    logic [1:0]              w_sew_code;
    logic [7:0]              w_sew_bits;
    logic [7:0]              w_half_bits;
    logic [3:0]              w_fold_init;
    logic [DATA_WIDTH-1:0]   w_sew_mask;
    logic [DATA_WIDTH-1:0]   w_half_mask;
    logic [DATA_WIDTH-1:0]   w_lane_a, w_lane_b, w_lane_y;

    assign w_sew_code = r_sew[1:0];

    always_comb begin
        w_sew_bits  = 8'd32;
        w_fold_init = 4'(F32);
        case (w_sew_code)
            SEW_8:   begin w_sew_bits = 8'd8;  w_fold_init = 4'(F8);  end
            SEW_16:  begin w_sew_bits = 8'd16; w_fold_init = 4'(F16); end
            default: begin w_sew_bits = 8'd32; w_fold_init = 4'(F32); end
        endcase
    end

    // r_fold counts remaining folds, so the active width is sew_bits << r_fold
    // and the half being folded away sits above sew_bits << (r_fold - 1).
    assign w_half_bits = w_sew_bits << (r_fold - 4'd1);
    assign w_half_mask = ~({DATA_WIDTH{1'b1}} << w_half_bits);
    assign w_sew_mask  = ~({DATA_WIDTH{1'b1}} << w_sew_bits);

    always_comb begin
        w_lane_a = r_acc;
        w_lane_b = in_data;
        case (r_state)
            ST_FOLD: begin
                w_lane_a = r_acc & w_half_mask;
                w_lane_b = (r_acc >> w_half_bits) & w_half_mask;
            end
            ST_SCALAR: begin
                w_lane_a = r_acc & w_sew_mask;
                w_lane_b = r_scalar & w_sew_mask;
            end
            default: ;
        endcase
    end

    vred_lane_op #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_lane_op (
        .a    (w_lane_a),
        .b    (w_lane_b),
        .sew  (w_sew_code),
        .opSel(r_opsel[1:0]),
        .y    (w_lane_y)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        busy         = 1'b1;
        case (r_state)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) w_state_next = ST_ACCUM;
            end
            ST_ACCUM: begin
                in_ready = 1'b1;
                if (in_valid && in_last)
                    w_state_next = (w_fold_init != 4'd0) ? ST_FOLD : ST_SCALAR;
            end
            ST_FOLD: begin
                if (r_fold == 4'd1) w_state_next = ST_SCALAR;
            end
            ST_SCALAR: w_state_next = ST_DONE;
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    assign out_data = (r_state == ST_DONE) ? r_acc : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc    <= '0;
            r_first  <= 1'b0;
            r_fold   <= '0;
            r_sew    <= '0;
            r_opsel  <= '0;
            r_scalar <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_sew    <= sew;
                        r_opsel  <= opSel;
                        r_scalar <= scalar_in;
                        r_first  <= 1'b1;
                    end
                end
                ST_ACCUM: begin
                    if (in_valid) begin
                        r_acc   <= r_first ? in_data : w_lane_y;
                        r_first <= 1'b0;
                        if (in_last) r_fold <= w_fold_init;
                    end
                end
                ST_FOLD: begin
                    r_acc  <= w_lane_y & w_half_mask;
                    r_fold <= r_fold - 4'd1;
                end
                ST_SCALAR: r_acc <= w_lane_y & w_sew_mask;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_vred_seq.sv
// Directed bench for vred_seq: hand-computed reductions per element width and
// operation, latency from the last-word edge, backpressure and mid-op reset.
module tb_vred_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  sew;
    logic [1:0]  opSel;
    logic [31:0] scalar_in;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_last;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_ready;
    logic        busy;

    int total = 0;
    int bad   = 0;

    vred_seq dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .sew      (sew),
        .opSel    (opSel),
        .scalar_in(scalar_in),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_last  (in_last),
        .in_ready (in_ready),
        .out_valid(out_valid),
        .out_data (out_data),
        .out_ready(out_ready),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // Runs one reduction from IDLE. lat counts clock edges after the edge that
    // accepts the last word, up to the first edge that samples out_valid high.
    // Control inputs are inverted right after start to show they are latched.
    task automatic do_op(input logic [1:0] s, input logic [1:0] op,
                         input logic [31:0] sc, input int n,
                         input logic [31:0] w0, input logic [31:0] w1,
                         output int lat, output logic [31:0] res,
                         output bit acc_ok, output bit to);
        acc_ok = 1'b1;
        start = 1'b1; sew = s; opSel = op; scalar_in = sc;
        @(posedge clk); #1;
        start = 1'b0; sew = ~s; opSel = ~op; scalar_in = ~sc;
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_data  = (i == 0) ? w0 : w1;
            in_last  = (i == n - 1);
            if (in_ready !== 1'b1) acc_ok = 1'b0;
            @(posedge clk); #1;
        end
        in_valid = 1'b0; in_last = 1'b0; in_data = '0;
        lat = 1;
        while (out_valid !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        to  = (out_valid !== 1'b1);
        res = out_data;
        $display("op sew=%0d opSel=%0d scalar=%h words=%0d -> out_data=%h lat=%0d",
                 s, op, sc, n, res, lat);
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; sew = '0; opSel = '0; scalar_in = '0;
        in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({in_ready, out_valid, busy} !== 3'b000 || out_data !== 32'h0) begin
            bad++;
            $display("FAIL reset_outputs: got rdy=%b vld=%b busy=%b data=%h want 0",
                     in_ready, out_valid, busy, out_data);
        end
        rst = 1'b0;
        in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        total++;
        if (in_ready !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL idle_no_accept: got rdy=%b busy=%b vld=%b want 0 0 0",
                     in_ready, busy, out_valid);
        end
        in_valid = 1'b0;
    endtask

    task automatic test_sum8();
        int lat; logic [31:0] res; bit ok, to;
        out_ready = 1'b1;
        do_op(2'd0, 2'b00, 32'h05, 2, 32'h04030201, 32'h01010101, lat, res, ok, to);
        total++;
        if (to || res !== 32'h00000013) begin
            bad++;
            $display("FAIL sum8_data: got %h (timeout=%0d) want 00000013", res, to);
        end
        total++;
        if (lat !== 4) begin
            bad++;
            $display("FAIL sum8_latency: got %0d want 4", lat);
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL sum8_in_ready: got 0 in ACCUM want 1");
        end
        @(posedge clk); #1;
        total++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL sum8_return_idle: got busy=%b vld=%b want 0 0", busy, out_valid);
        end
    endtask

    task automatic test_min16();
        int lat; logic [31:0] res; bit ok, to;
        out_ready = 1'b1;
        do_op(2'd1, 2'b10, 32'h0001, 1, 32'h0003FFFE, 32'h0, lat, res, ok, to);
        total++;
        if (to || res !== 32'h0000FFFE || lat !== 3) begin
            bad++;
            $display("FAIL min16: got data=%h lat=%0d want 0000FFFE lat=3", res, lat);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_max32();
        int lat; logic [31:0] res; bit ok, to;
        out_ready = 1'b1;
        do_op(2'd2, 2'b11, 32'h7FFFFFFF, 1, 32'h80000000, 32'h0, lat, res, ok, to);
        total++;
        if (to || res !== 32'h7FFFFFFF || lat !== 2) begin
            bad++;
            $display("FAIL max32: got data=%h lat=%0d want 7FFFFFFF lat=2", res, lat);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_wrap8();
        int lat; logic [31:0] res; bit ok, to;
        out_ready = 1'b1;
        do_op(2'd0, 2'b01, 32'h00, 1, 32'hFF000001, 32'h0, lat, res, ok, to);
        total++;
        if (to || res !== 32'h00000000) begin
            bad++;
            $display("FAIL wrap8: got %h want 00000000", res);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_misc_lanes();
        int lat; logic [31:0] res; bit ok, to;
        out_ready = 1'b1;
        // signed byte max across two words; scalar 0x80 is -128
        do_op(2'd0, 2'b11, 32'hFFFFFF80, 2, 32'h7F80FF01, 32'h02FE7F00, lat, res, ok, to);
        total++;
        if (to || res !== 32'h0000007F) begin
            bad++;
            $display("FAIL max8: got %h want 0000007F", res);
        end
        @(posedge clk); #1;
        // 16b sum with no carry between halfwords; scalar upper bits ignored
        do_op(2'd1, 2'b00, 32'hABCD0001, 2, 32'h0001FFFF, 32'hFFFF0002, lat, res, ok, to);
        total++;
        if (to || res !== 32'h00000002 || lat !== 3) begin
            bad++;
            $display("FAIL sum16_nocarry: got data=%h lat=%0d want 00000002 lat=3", res, lat);
        end
        @(posedge clk); #1;
        // reserved sew code behaves as 32b
        do_op(2'd3, 2'b01, 32'h00000001, 2, 32'hFFFFFFFF, 32'h00000010, lat, res, ok, to);
        total++;
        if (to || res !== 32'h00000010 || lat !== 2) begin
            bad++;
            $display("FAIL sew_reserved: got data=%h lat=%0d want 00000010 lat=2", res, lat);
        end
        @(posedge clk); #1;
        // signed 8b min: 0x80 is the most negative byte
        do_op(2'd0, 2'b10, 32'h00000010, 1, 32'h7F10C080, 32'h0, lat, res, ok, to);
        total++;
        if (to || res !== 32'h00000080) begin
            bad++;
            $display("FAIL min8: got %h want 00000080", res);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        int lat; logic [31:0] res; bit ok, to;
        out_ready = 1'b0;
        do_op(2'd0, 2'b00, 32'h05, 2, 32'h04030201, 32'h01010101, lat, res, ok, to);
        total++;
        if (to || res !== 32'h00000013) begin
            bad++;
            $display("FAIL bp_first_result: got %h want 00000013", res);
        end
        for (int c = 0; c < 3; c++) begin
            start = 1'b1; in_valid = 1'b1; in_data = 32'hDEADBEEF; in_last = 1'b1;
            @(posedge clk); #1;
            total++;
            if (out_valid !== 1'b1 || out_data !== 32'h00000013 || in_ready !== 1'b0) begin
                bad++;
                $display("FAIL bp_hold[%0d]: got vld=%b data=%h rdy=%b want 1 00000013 0",
                         c, out_valid, out_data, in_ready);
            end
        end
        start = 1'b0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        total++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL bp_release: got vld=%b busy=%b want 0 0", out_valid, busy);
        end
        @(posedge clk); #1;
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL bp_no_new_op: got busy=%b want 0", busy);
        end
    endtask

    task automatic test_reset_mid();
        int lat; logic [31:0] res; bit ok, to;
        out_ready = 1'b1;
        start = 1'b1; sew = 2'd0; opSel = 2'b11; scalar_in = 32'h7F;
        @(posedge clk); #1;
        start = 1'b0;
        in_valid = 1'b1; in_data = 32'h7F7F7F7F; in_last = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        total++;
        if ({in_ready, out_valid, busy} !== 3'b000 || out_data !== 32'h0) begin
            bad++;
            $display("FAIL reset_mid_outputs: got rdy=%b vld=%b busy=%b data=%h want 0",
                     in_ready, out_valid, busy, out_data);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        do_op(2'd0, 2'b00, 32'h05, 2, 32'h04030201, 32'h01010101, lat, res, ok, to);
        total++;
        if (to || res !== 32'h00000013 || lat !== 4) begin
            bad++;
            $display("FAIL reset_mid_rerun: got data=%h lat=%0d want 00000013 lat=4", res, lat);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_sum8();
        test_min16();
        test_max32();
        test_wrap8();
        test_misc_lanes();
        test_backpressure();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vred_seq.md
VRED_SEQ -- requirements
Module: vred_seq

Interface
REQ-001 SHALL have parameters: DATA_WIDTH, default 32, width of one source word and of the result; OPSEL_WIDTH, default 2, operation select width; SEW_WIDTH, default 2, element-width code width.
REQ-002 SHALL have ports, one per line:
  clk  in  1  clock; reset rst, synchronous, active-high
  rst  in  1  synchronous active-high reset
  start  in  1  begin a reduction; sampled in IDLE only
  sew  in  SEW_WIDTH  0=8b, 1=16b, 2=32b, 3=reserved (treated as 32b); latched at start
  opSel  in  OPSEL_WIDTH  00/01=sum, 10=signed min, 11=signed max; latched at start
  scalar_in  in  DATA_WIDTH  vs1[0]; low SEW bits used; latched at start
  in_valid  in  1  source word valid
  in_data  in  DATA_WIDTH  packed SEW lanes of vs2
  in_last  in  1  marks final source word
  in_ready  out  1  word accepted when in_valid & in_ready
  out_valid  out  1  result valid
  out_data  out  DATA_WIDTH  result, zero-extended above SEW
  out_ready  in  1  result consumed when out_valid & out_ready
  busy  out  1  high in every state except IDLE

Function
REQ-003 SHALL implement FSM IDLE, ACCUM, FOLD, SCALAR, DONE.
REQ-004 IDLE: in_ready=0, out_valid=0; start=1 latches sew/opSel/scalar_in, sets first flag, goes to ACCUM.
REQ-005 ACCUM: in_ready=1; on handshake acc <= first ? in_data : lane_op(acc,in_data) per SEW lane; first cleared.
REQ-006 Handshake with in_last=1 (including the first word): F=2 for 8b, 1 for 16b, 0 for 32b; go to FOLD if F>0, else SCALAR.
REQ-007 FOLD: each cycle lane_op(acc low half, acc high half) over the active width, high half zeroed; 8b: 32->16->8; 16b: 32->16; then SCALAR.
REQ-008 SCALAR: acc[SEW-1:0] <= lane_op(acc[SEW-1:0], scalar[SEW-1:0]); bits above SEW zeroed; go to DONE.
REQ-009 DONE: out_valid=1, out_data=acc; held stable until out_ready=1, then IDLE.
REQ-010 Sum SHALL wrap modulo 2^SEW per lane; no carry between lanes.
REQ-011 Min/max SHALL compare lanes as two's-complement SEW values.
REQ-012 out_valid SHALL first assert 2+F cycles after the clock edge accepting the in_last word.
REQ-013 start outside IDLE SHALL be ignored; in_valid outside ACCUM SHALL NOT be accepted (in_ready=0).
REQ-014 out_ready without out_valid SHALL have no effect.
REQ-015 sew/opSel/scalar_in changes after start SHALL NOT affect the running reduction.

Reset
REQ-016 rst SHALL force IDLE, acc=0, first=0, latched fields=0, in_ready=0, out_valid=0, out_data=0, busy=0 on the next edge, from any state.
REQ-017 Reset mid-operation SHALL discard partial results; the next start SHALL behave as after power-up.

Structure
REQ-018 A shared package SHALL hold FSM state encoding, SEW codes, and opSel codes.
REQ-019 Per-lane arithmetic SHALL be one combinational sub-module vred_lane_op (inputs a, b, sew, opSel; output packed lane result), instantiated once and time-shared across ACCUM/FOLD/SCALAR.
REQ-020 Only acc, FSM state, fold counter, first flag and latched controls SHALL be registers.

Verification
REQ-021 8b sum: scalar 0x05; words 0x04030201, 0x01010101(last) -> out_data 0x00000013, out_valid 4 cycles after last-word edge.
REQ-022 16b min: scalar 0x0001; single word 0x0003FFFE(last) -> out_data 0x0000FFFE after 3 cycles.
REQ-023 32b max: scalar 0x7FFFFFFF; single word 0x80000000(last) -> out_data 0x7FFFFFFF after 2 cycles.
REQ-024 8b sum wrap: scalar 0x00; word 0xFF000001(last) -> out_data 0x00000000.
REQ-025 Backpressure: out_ready=0 for 3 cycles in DONE, start pulsed and in_valid=1 -> out_data stable, in_ready=0, no new op; out_ready=1 -> IDLE next edge.
REQ-026 rst asserted in ACCUM after one word -> all outputs 0 next cycle; following REQ-021 stimulus yields 0x00000013.
